div_unit: RTL and testbench

Multi-cycle integer divider for the EX stage, implementing RV32M DIV, DIVU, REM and REMU. It is the iterative inverse of the carry-lookahead adder path: a restoring radix-2 divider that retires one quotient bit per cycle using a shared subtractor. The EX stage stalls on `busy` and captures `result` on the single-cycle `done` pulse.

---
 rtl/div_pkg.sv | 25 ++
 rtl/addsub_nbits.sv | 67 ++++++
 rtl/div_unit.sv | 181 ++++++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared encodings for the iterative divider: the RV32M
//             operation codes carried on `op` and the controller state type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Operation encodings. Bit 0 set means unsigned, bit 1 set means remainder.
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_nbits.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_nbits
//  Purpose  : WIDTH-bit adder/subtractor built from 4-bit carry-lookahead
//             slices. The operands are sign-extended into the padding of the
//             top slice so the slice count never depends on WIDTH being a
//             multiple of four.
//  Ports    : a, b   - operands (WIDTH bits)
//             sub    - 1: sum = a - b, 0: sum = a + b
//             sum    - result (WIDTH bits)
//             carry  - carry out of bit WIDTH-1 (for subtraction: 1 = no
//                      borrow, i.e. a >= b as unsigned values)
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_nbits #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Always at least one padding bit, so the pad slice ranges are never empty.
  localparam int PW     = 4 * ((WIDTH + 4) / 4);
  localparam int NSLICE = PW / 4;

  logic [WIDTH-1:0] b_inv;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [PW:0]      carries;
  logic [PW-1:0]    sum_full;
  logic             unused_pad;

  assign b_inv      = sub ? ~b : b;
  assign a_ext      = {{(PW-WIDTH){a[WIDTH-1]}}, a};
  assign b_ext      = {{(PW-WIDTH){b_inv[WIDTH-1]}}, b_inv};
  assign carries[0] = sub;

  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a_ext[4*s +: 4] & b_ext[4*s +: 4];
    assign p    = a_ext[4*s +: 4] ^ b_ext[4*s +: 4];
    assign c[0] = carries[4*s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);

    assign carries[4*s+1 +: 4] = c[4:1];
    assign sum_full[4*s +: 4]  = p ^ c[3:0];
  end

  assign sum   = sum_full[WIDTH-1:0];
  assign carry = carries[WIDTH];

  // Padding sum bits and the final slice carry only exist for sign extension.
  assign unused_pad = ^{sum_full[PW-1:WIDTH], carries[PW]};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU. One
//             quotient bit per cycle; a single shared subtractor performs the
//             trial subtraction in CALC and the sign negation in FIX.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             start         - request (accepted when busy = 0)
//             op            - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//             rs1, rs2      - dividend, divisor (sampled with start)
//             busy          - operation in progress (CALC or FIX)
//             done          - one-cycle pulse, result valid
//             result        - quotient/remainder, held until next accept
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONE     = XLEN'(1);

  div_state_t      state;
  logic [1:0]      op_q;
  logic            quo_neg;      // operand signs differ
  logic            rem_neg;      // dividend was negative
  logic            special;      // quo/rem already hold the final values
  logic [XLEN-1:0] dmag;
  logic [XLEN-1:0] rem;          // partial remainder; always < dmag between steps
  logic [XLEN-1:0] quo;
  logic [CW-1:0]   count;

  // Accept-time decode
  logic            accept;
  logic            signed_op;
  logic            rs1_neg;
  logic            rs2_neg;
  logic [XLEN-1:0] rs1_mag;
  logic [XLEN-1:0] rs2_mag;
  logic            div_zero;
  logic            overflow;

  // Shared subtractor
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   add_a;
  logic [XLEN:0]   add_b;
  logic [XLEN:0]   add_sum;
  logic            add_carry;
  logic            unused_sum_msb;
  logic            fix_negate;

  assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign signed_op = (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  assign rs1_neg   = signed_op && rs1[XLEN-1];
  assign rs2_neg   = signed_op && rs2[XLEN-1];
  // The most negative value negates to itself, which is its unsigned magnitude.
  assign rs1_mag   = rs1_neg ? (~rs1 + ONE) : rs1;
  assign rs2_mag   = rs2_neg ? (~rs2 + ONE) : rs2;
  assign div_zero  = (rs2 == '0);
  assign overflow  = signed_op && (rs1 == MIN_NEG) && (rs2 == '1);

  // {rem, quo} shifted left by one: the XLEN+1-bit partial remainder.
  assign shifted   = {rem, quo[XLEN-1]};

  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == ST_CALC) begin
      add_a = shifted;
      add_b = {1'b0, dmag};
    end else begin
      // FIX: 0 - value gives the two's-complement negation.
      add_b = {1'b0, (op_q[1] ? rem : quo)};
    end
  end

  addsub_nbits #(
    .WIDTH (XLEN + 1)
  ) u_addsub (
    .a     (add_a),
    .b     (add_b),
    .sub   (1'b1),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Trial results are below dmag and negations fit in XLEN bits.
  assign unused_sum_msb = add_sum[XLEN];
  assign fix_negate     = op_q[1] ? rem_neg : quo_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_q    <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      special <= 1'b0;
      dmag    <= '0;
      rem     <= '0;
      quo     <= '0;
      count   <= '0;
      result  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            op_q    <= op;
            quo_neg <= rs1_neg ^ rs2_neg;
            rem_neg <= rs1_neg;
            dmag    <= rs2_mag;
            count   <= CNT_LAST;
            if (div_zero) begin
              special <= 1'b1;
              quo     <= '1;
              rem     <= rs1;
              state   <= ST_FIX;
            end else if (overflow) begin
              special <= 1'b1;
              quo     <= rs1;
              rem     <= '0;
              state   <= ST_FIX;
            end else begin
              special <= 1'b0;
              quo     <= rs1_mag;
              rem     <= '0;
              state   <= ST_CALC;
            end
          end else if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end

        ST_CALC: begin
          // Carry out of the subtract means no borrow: trial >= 0.
          if (add_carry) begin
            rem <= add_sum[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end else begin
            rem <= shifted[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= ST_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end

        ST_FIX: begin
          if (!special && fix_negate) begin
            result <= add_sum[XLEN-1:0];
          end else begin
            result <= op_q[1] ? rem : quo;
          end
          state <= ST_DONE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CALC) || (state == ST_FIX);
  assign done = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Scoreboard bench for div_unit. The driver pushes expected
//             result and expected done cycle on each tracked request; a
//             monitor pops and compares on every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [XLEN-1:0] exp_res_q[$];
  int              exp_cyc_q[$];
  string           exp_name_q[$];

  div_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result 0x%08h at cycle %0d, expected no done", result, cyc);
      end else begin
        automatic logic [XLEN-1:0] er = exp_res_q.pop_front();
        automatic int              ec = exp_cyc_q.pop_front();
        automatic string           en = exp_name_q.pop_front();
        check({en, "_result"}, result, er);
        check({en, "_latency"}, cyc, ec);
      end
    end
  end

  // Called at a negedge. The accept edge moves cyc from k to k+1; done is
  // expected at cyc k+XLEN+2 (normal) or k+2 (special case).
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp,
                       input bit special, input bit track);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    if (track) begin
      exp_res_q.push_back(exp);
      exp_cyc_q.push_back(cyc + (special ? 2 : XLEN + 2));
      exp_name_q.push_back(name);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge on which done is high.
  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done after %0d cycles, expected done", name, n);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    rs1   = '0;
    rs2   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy",   {31'b0, busy}, 32'h0);
    check("reset_done",   {31'b0, done}, 32'h0);
    check("reset_result", result,        32'h0);
    @(negedge clk);

    // Back-to-back: REMU issued in the DONE cycle of DIVU.
    issue("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 1'b0, 1'b1);
    wait_done("divu_100_7");
    issue("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b1);
    wait_done("remu_100_7");

    // Signed operations and the most negative dividend.
    issue("div_m7_2",  2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done("div_m7_2");
    issue("rem_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b1);
    wait_done("rem_m7_2");
    issue("rem_7_m2",  2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    wait_done("rem_7_m2");
    issue("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000, 1'b0, 1'b1);
    wait_done("div_min_2");
    issue("remu_max_10", 2'b11, 32'hFFFF_FFFF, 32'd10, 32'd5, 1'b0, 1'b1);
    wait_done("remu_max_10");

    // Special cases: two-cycle latency.
    issue("divu_5_0",  2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("divu_5_0");
    issue("rem_5_0",   2'b10, 32'd5, 32'd0, 32'd5, 1'b1, 1'b1);
    wait_done("rem_5_0");
    issue("div_ovf",   2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    wait_done("div_ovf");
    issue("rem_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    wait_done("rem_ovf");
    @(negedge clk);

    // start pulses while busy must be ignored.
    issue("divu_busy", 2'b01, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("busy_during_calc", {31'b0, busy}, 32'h1);
    issue("ignored_a", 2'b11, 32'd7, 32'd1, 32'd0, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    issue("ignored_b", 2'b10, 32'd9, 32'd4, 32'd0, 1'b1, 1'b0);
    wait_done("divu_busy");
    @(negedge clk);

    // Reset in the middle of CALC aborts the operation.
    issue("aborted", 2'b01, 32'd50, 32'd5, 32'd10, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy",   {31'b0, busy}, 32'h0);
    check("abort_done",   {31'b0, done}, 32'h0);
    check("abort_result", result,        32'h0);
    issue("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 1'b1);
    wait_done("divu_9_3");

    repeat (5) @(negedge clk);
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_res_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
